axi_mem_slave: RTL

//   AXI4 slave memory responder: the far end of the systolic-array AXI4 master.

---
 rtl/axi_mem_slave_if.sv | 67 ++++++
 rtl/axi_mem_slave.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/axi_mem_slave_if.sv
// AXI4 read/write channel bundle between a master and axi_mem_slave.
// Sideband prot is carried for completeness; the slave ignores it.
interface axi_mem_slave_if #(
  parameter int AW = 32,
  parameter int DW = 64
);
  logic [AW-1:0] araddr;
  logic          arid;
  logic [7:0]    arlen;
  logic [2:0]    arsize;
  logic [1:0]    arburst;
  logic [2:0]    arprot;
  logic          arvalid;
  logic          arready;

  logic [DW-1:0] rdata;
  logic          rid;
  logic [1:0]    rresp;
  logic          rlast;
  logic          rvalid;
  logic          rready;

  logic [AW-1:0] awaddr;
  logic          awid;
  logic [7:0]    awlen;
  logic [2:0]    awsize;
  logic [1:0]    awburst;
  logic [2:0]    awprot;
  logic          awvalid;
  logic          awready;

  logic [DW-1:0] wdata;
  logic          wlast;
  logic          wvalid;
  logic          wready;

  logic          bid;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready;

  modport slave (
    input  araddr, arid, arlen, arsize, arburst, arprot, arvalid,
    output arready,
    output rdata, rid, rresp, rlast, rvalid,
    input  rready,
    input  awaddr, awid, awlen, awsize, awburst, awprot, awvalid,
    output awready,
    input  wdata, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );

  modport master (
    output araddr, arid, arlen, arsize, arburst, arprot, arvalid,
    input  arready,
    input  rdata, rid, rresp, rlast, rvalid,
    output rready,
    output awaddr, awid, awlen, awsize, awburst, awprot, awvalid,
    input  awready,
    output wdata, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );
endinterface

// File: rtl/axi_mem_slave.sv
// AXI4 slave memory: INCR read bursts and write bursts on a word-addressed RAM.
// Read data one cycle after AR handshake, then one beat per R handshake; B after counted last W beat.
module axi_mem_slave #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int DEPTH_WORDS    = 256
) (
  input logic             clk,
  input logic             rst_n,
  axi_mem_slave_if.slave  s_axi
);
  localparam int            AW       = AXI_ADDR_WIDTH;
  localparam int            DW       = AXI_DATA_WIDTH;
  localparam int            SHIFT    = $clog2(DW / 8);
  localparam int            IW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [2:0]    SIZE_ENC = 3'(SHIFT);
  localparam logic [AW-1:0] DEPTH_AW = AW'(DEPTH_WORDS);
  localparam logic [1:0]    INCR     = 2'b01;
  localparam logic [1:0]    OKAY     = 2'b00;
  localparam logic [1:0]    SLVERR   = 2'b10;

  localparam logic [0:0] R_IDLE  = 1'b0;
  localparam logic [0:0] R_BURST = 1'b1;
  localparam logic [1:0] W_IDLE  = 2'd0;
  localparam logic [1:0] W_DATA  = 2'd1;
  localparam logic [1:0] W_RESP  = 2'd2;

  logic [DW-1:0] mem [DEPTH_WORDS];

  logic unused_prot;
  assign unused_prot = ^{s_axi.arprot, s_axi.awprot};

  // ---------------- read channel ----------------
  logic [0:0]    r_state;
  logic [AW-1:0] r_idx;
  logic [7:0]    r_cnt;
  logic [7:0]    r_len;
  logic          r_bad;

  logic [AW-1:0] ar_idx;
  logic          ar_bad;
  logic          ar_hs;
  logic          r_hs;
  logic [AW-1:0] rd_idx;
  logic          rd_err;

  assign ar_idx = s_axi.araddr >> SHIFT;
  assign ar_bad = (s_axi.arburst != INCR) || (s_axi.arsize != SIZE_ENC);
  assign ar_hs  = s_axi.arvalid && s_axi.arready;
  assign r_hs   = s_axi.rvalid && s_axi.rready;

  // In IDLE the first beat comes straight from the AR fields; afterwards from the counters.
  assign rd_idx = (r_state == R_IDLE) ? ar_idx : r_idx;
  assign rd_err = ((r_state == R_IDLE) ? ar_bad : r_bad) || (rd_idx >= DEPTH_AW);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= R_IDLE;
      r_idx         <= '0;
      r_cnt         <= '0;
      r_len         <= '0;
      r_bad         <= 1'b0;
      s_axi.arready <= 1'b1;
      s_axi.rvalid  <= 1'b0;
      s_axi.rlast   <= 1'b0;
      s_axi.rdata   <= '0;
      s_axi.rresp   <= OKAY;
      s_axi.rid     <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            r_state       <= R_BURST;
            s_axi.arready <= 1'b0;
            s_axi.rid     <= s_axi.arid;
            r_len         <= s_axi.arlen;
            r_bad         <= ar_bad;
            r_idx         <= ar_idx + 1'b1;
            r_cnt         <= 8'd1;
            s_axi.rvalid  <= 1'b1;
            s_axi.rlast   <= (s_axi.arlen == 8'd0);
            s_axi.rresp   <= rd_err ? SLVERR : OKAY;
            s_axi.rdata   <= rd_err ? '0 : mem[rd_idx[IW-1:0]];
          end
        end
        default: begin
          if (r_hs) begin
            if (s_axi.rlast) begin
              r_state       <= R_IDLE;
              s_axi.arready <= 1'b1;
              s_axi.rvalid  <= 1'b0;
              s_axi.rlast   <= 1'b0;
            end else begin
              r_idx         <= r_idx + 1'b1;
              r_cnt         <= r_cnt + 8'd1;
              s_axi.rlast   <= (r_cnt == r_len);
              s_axi.rresp   <= rd_err ? SLVERR : OKAY;
              s_axi.rdata   <= rd_err ? '0 : mem[rd_idx[IW-1:0]];
            end
          end
        end
      endcase
    end
  end

  // ---------------- write channel ----------------
  logic [1:0]    w_state;
  logic [AW-1:0] w_idx;
  logic [7:0]    w_cnt;
  logic [7:0]    w_len;
  logic          w_bad;
  logic          w_err;

  logic [AW-1:0] aw_idx;
  logic          aw_bad;
  logic          aw_hs;
  logic          w_hs;
  logic          w_final;
  logic          w_beat_err;
  logic          wr_en;

  assign aw_idx     = s_axi.awaddr >> SHIFT;
  assign aw_bad     = (s_axi.awburst != INCR) || (s_axi.awsize != SIZE_ENC);
  assign aw_hs      = s_axi.awvalid && s_axi.awready;
  assign w_hs       = s_axi.wvalid && s_axi.wready;
  assign w_final    = (w_cnt == w_len);
  // Termination follows the beat count; wlast only feeds the error flag.
  assign w_beat_err = w_bad || (w_idx >= DEPTH_AW) || (s_axi.wlast != w_final);
  assign wr_en      = w_hs && !w_bad && (w_idx < DEPTH_AW);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[w_idx[IW-1:0]] <= s_axi.wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state       <= W_IDLE;
      w_idx         <= '0;
      w_cnt         <= '0;
      w_len         <= '0;
      w_bad         <= 1'b0;
      w_err         <= 1'b0;
      s_axi.awready <= 1'b1;
      s_axi.wready  <= 1'b0;
      s_axi.bvalid  <= 1'b0;
      s_axi.bresp   <= OKAY;
      s_axi.bid     <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_hs) begin
            w_state       <= W_DATA;
            s_axi.awready <= 1'b0;
            s_axi.wready  <= 1'b1;
            s_axi.bid     <= s_axi.awid;
            w_idx         <= aw_idx;
            w_cnt         <= 8'd0;
            w_len         <= s_axi.awlen;
            w_bad         <= aw_bad;
            w_err         <= 1'b0;
          end
        end
        W_DATA: begin
          if (w_hs) begin
            w_idx <= w_idx + 1'b1;
            w_cnt <= w_cnt + 8'd1;
            w_err <= w_err || w_beat_err;
            if (w_final) begin
              w_state      <= W_RESP;
              s_axi.wready <= 1'b0;
              s_axi.bvalid <= 1'b1;
              s_axi.bresp  <= (w_err || w_beat_err) ? SLVERR : OKAY;
            end
          end
        end
        default: begin
          if (s_axi.bready) begin
            w_state       <= W_IDLE;
            s_axi.bvalid  <= 1'b0;
            s_axi.awready <= 1'b1;
          end
        end
      endcase
    end
  end
endmodule
